// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst scheduler for one async-FIFO read port; FIFO_RD_ARB_WATCHDOG_EN adds a stall watchdog.
// Latency: grant one cycle after req, out_valid/out_data/out_id one cycle after fifo_rd.
// Backpressure: fifo_empty stalls the burst with grant held; dropping req ends the burst.
module fifo_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_D   = 8,
    parameter int BURST_LEN = 4,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic               r_clk,
    input  logic               r_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               fifo_empty,
    input  logic [WIDTH_D-1:0] fifo_rdata,
    output logic               fifo_rd,
    output logic [NUM_REQ-1:0] grant,
    output logic [WIDTH_D-1:0] out_data,
    output logic               out_valid,
    output logic [IDW-1:0]     out_id
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [3:0]         LAST_BEAT = 4'(BURST_LEN - 1);
    localparam logic [IDW-1:0]     LAST_IDX  = IDW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     g;
    logic [IDW-1:0]     sel_idx;
    logic [IDW-1:0]     cand;
    logic               sel_found;
    logic [3:0]         beat_cnt;
    logic               req_g;
    logic               last_beat;
    logic               burst_exit;
    logic               wd_hit;
    logic [WIDTH_D-1:0] data_q;

    assign req_g      = req[g];
    assign fifo_rd    = (state == BURST) && req_g && !fifo_empty;
    assign last_beat  = fifo_rd && (beat_cnt == LAST_BEAT);
    assign burst_exit = last_beat || !req_g || wd_hit;

    // First set request scanning upward from the priority pointer, with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NUM_REQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state    <= IDLE;
            grant    <= '0;
            g        <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant    <= ONE_HOT0 << sel_idx;
                        g        <= sel_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (fifo_rd) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                    if (burst_exit) begin
                        grant <= '0;
                        ptr   <= (g == LAST_IDX) ? '0 : g + IDW'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_ARB_WATCHDOG_EN
    logic [3:0] stall_cnt;

    // Fifteenth consecutive starved cycle releases the grant like a normal exit.
    assign wd_hit = (state == BURST) && req_g && fifo_empty && (stall_cnt == 4'd14);

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE || fifo_rd) begin
            stall_cnt <= '0;
        end else if (req_g && fifo_empty) begin
            stall_cnt <= stall_cnt + 4'd1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    // g is left untouched in IDLE so the final beat keeps its owner's id.
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            data_q    <= '0;
        end else begin
            out_valid <= fifo_rd;
            out_id    <= g;
            if (out_valid) begin
                data_q <= fifo_rdata;
            end
        end
    end

    assign out_data = out_valid ? fifo_rdata : data_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_fifo_rd_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH_D   = 8;
    localparam int BURST_LEN = 4;
    localparam int IDW       = 2;
`ifdef FIFO_RD_ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic               r_clk = 1'b0;
    logic               r_rst;
    logic [NUM_REQ-1:0] req;
    logic               fifo_empty;
    logic [WIDTH_D-1:0] fifo_rdata;
    logic               fifo_rd;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH_D-1:0] out_data;
    logic               out_valid;
    logic [IDW-1:0]     out_id;

    fifo_rd_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH_D(WIDTH_D), .BURST_LEN(BURST_LEN)) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .req        (req),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .grant      (grant),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_id     (out_id)
    );

    always #5 r_clk = ~r_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: who owns the port, words moved so far, starved cycles, next in line.
    int owner = -1;
    int ptr   = 0;
    int beats = 0;
    int stall = 0;

    logic [WIDTH_D-1:0] env_q[$];
    logic [WIDTH_D-1:0] mdl_q[$];
    logic [WIDTH_D-1:0] word_ctr = 8'h10;
    logic [NUM_REQ-1:0] glog[$];
    logic [NUM_REQ-1:0] prev_grant = '0;
    int                 valid_cnt[NUM_REQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            env_q.push_back(word_ctr);
            mdl_q.push_back(word_ctr);
            word_ctr = word_ctr + 8'd1;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_REQ; i++) valid_cnt[i] = 0;
        glog.delete();
    endtask

    task automatic step(input logic [NUM_REQ-1:0] r, input bit force_empty);
        bit                 exp_rd;
        bit                 env_rd;
        bit                 done;
        int                 nid;
        logic [WIDTH_D-1:0] nw;
        logic [NUM_REQ-1:0] exp_grant;
        req        = r;
        fifo_empty = force_empty || (env_q.size() == 0);
        #1;
        exp_rd = (owner >= 0) && req[owner] && !fifo_empty;
        chk("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
        env_rd = fifo_rd;
        nid    = (owner >= 0) ? owner : 0;
        nw     = 'x;
        if (exp_rd && mdl_q.size() > 0) nw = mdl_q.pop_front();
        if (owner < 0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner < 0 && req[(ptr + i) % NUM_REQ]) owner = (ptr + i) % NUM_REQ;
            end
            beats = 0;
            stall = 0;
        end else begin
            done = 1'b0;
            if (exp_rd) begin
                beats++;
                stall = 0;
                if (beats == BURST_LEN) done = 1'b1;
            end else if (!req[owner]) begin
                done = 1'b1;
            end else begin
                stall++;
                if (WD && stall == 15) done = 1'b1;
            end
            if (done) begin
                ptr   = (owner + 1) % NUM_REQ;
                owner = -1;
            end
        end
        @(posedge r_clk);
        #1;
        if (env_rd && env_q.size() > 0) fifo_rdata = env_q.pop_front();
        else fifo_rdata = WIDTH_D'($urandom);
        #1;
        exp_grant = (owner >= 0) ? (NUM_REQ'(1) << owner) : '0;
        chk("grant", 32'(grant), 32'(exp_grant));
        chk("out_valid", 32'(out_valid), 32'(exp_rd));
        if (exp_rd) begin
            chk("out_id", 32'(out_id), 32'(nid));
            chk("out_data", 32'(out_data), 32'(nw));
        end
        if (out_valid === 1'b1) valid_cnt[out_id]++;
        if (grant != '0 && grant !== prev_grant) glog.push_back(grant);
        prev_grant = grant;
    endtask

    task automatic apply_reset();
        r_rst = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_id", 32'(out_id), 32'h0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'h0);
        owner      = -1;
        ptr        = 0;
        beats      = 0;
        stall      = 0;
        prev_grant = '0;
        @(posedge r_clk);
        #1;
        r_rst = 1'b1;
        #1;
    endtask

    logic [NUM_REQ-1:0] rr_exp[5];
    logic [NUM_REQ-1:0] rnd_req;

    initial begin
        rr_exp     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        r_rst      = 1'b1;
        req        = '0;
        fifo_empty = 1'b1;
        fifo_rdata = '0;
        clear_counts();
        #1;
        r_rst = 1'b0;
        #1;
        chk("init_grant", 32'(grant), 32'h0);
        chk("init_out_valid", 32'(out_valid), 32'h0);
        chk("init_out_id", 32'(out_id), 32'h0);
        chk("init_out_data", 32'(out_data), 32'h0);
        chk("init_fifo_rd", 32'(fifo_rd), 32'h0);
        @(posedge r_clk);
        #1;
        r_rst = 1'b1;

        // Reset in the middle of requester 1's burst, then requester 0 wins first.
        push_words(6);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
        chk("mid_grant_before_rst", 32'(grant), 32'h2);
        apply_reset();
        step(4'b0011, 1'b0);
        chk("post_rst_first_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 4; i++) step(4'b0011, 1'b0);

        // Single requester, ten words available.
        apply_reset();
        env_q.delete();
        mdl_q.delete();
        clear_counts();
        push_words(10);
        for (int i = 0; i < 15; i++) step(4'b0001, 1'b0);
        chk("single_valid_cnt", 32'(valid_cnt[0]), 32'd10);

        // All four requesting with a full FIFO.
        apply_reset();
        clear_counts();
        push_words(40);
        for (int i = 0; i < 25; i++) step(4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_grant%0d", i),
                (i < glog.size()) ? 32'(glog[i]) : 32'hDEAD, 32'(rr_exp[i]));
        end

        // Empty stall inside requester 2's burst.
        apply_reset();
        clear_counts();
        push_words(8);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0100, 1'b1);
        chk("stall_grant_held", 32'(grant), 32'h4);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0);
        chk("stall_burst_done", 32'(grant), 32'h0);
        step(4'b0000, 1'b0);
        chk("stall_valid_cnt", 32'(valid_cnt[2]), 32'd4);

        // Requester 1 gives up after two beats.
        apply_reset();
        clear_counts();
        push_words(8);
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
        step(4'b1001, 1'b0);
        step(4'b1001, 1'b0);
        chk("early_next_grant", 32'(grant), 32'h8);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("early_valid_cnt", 32'(valid_cnt[1]), 32'd2);

        // Requester 3 starved for twenty cycles.
        apply_reset();
        step(4'b1000, 1'b1);
        for (int i = 0; i < 15; i++) step(4'b1000, 1'b1);
        chk("wd_grant_after_15", 32'(grant), WD ? 32'h0 : 32'h8);
        step(4'b1001, 1'b1);
        chk("wd_ptr_advanced", 32'(grant), WD ? 32'h1 : 32'h8);
        for (int i = 0; i < 4; i++) step(4'b1000, 1'b1);

        // Random traffic.
        apply_reset();
        rnd_req = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0 && env_q.size() < 24) push_words($urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) rnd_req = NUM_REQ'($urandom);
            step(rnd_req, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
